// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pdata;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;
    logic             done;

    // Producer / consumer side: offers words and paces the serial stream.
    modport master (
        output load_valid,
        output pdata,
        output shift_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  sout_last,
        input  busy,
        input  done
    );

    // Serializer side.
    modport slave (
        input  load_valid,
        input  pdata,
        input  shift_en,
        output load_ready,
        output sout,
        output sout_valid,
        output sout_last,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word over a
// valid/ready handshake and streams it out one bit per enabled cycle,
// flagging the last bit and pulsing done after it is consumed.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    piso_serializer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             last_bit;
    logic             last_taken;
    logic             ready;
    logic             accept;

    // Handshake decode: a reload is only possible as the last bit leaves.
    always_comb begin
        last_bit   = (state == SHIFT) && (cnt == '0);
        last_taken = last_bit && bus.shift_en;
        ready      = (state == IDLE) || last_taken;
        accept     = bus.load_valid && ready;
    end

    // Shift toward the output end, zero-filling behind.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (last_taken) state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load-or-shift selection, remaining-bit counter, done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_taken;
            if (accept) begin
                shreg <= bus.pdata;
                cnt   <= CW'(WIDTH - 1);
            end else if ((state == SHIFT) && bus.shift_en) begin
                shreg <= shifted;
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    // Output decode.
    always_comb begin
        bus.load_ready = ready;
        bus.sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        bus.sout_valid = (state == SHIFT);
        bus.busy       = (state == SHIFT);
        bus.sout_last  = last_bit;
        bus.done       = done_q;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer for the shift-register datapath. It accepts a WIDTH-bit word over a valid/ready load handshake and streams it out one bit per enabled cycle. It marks the last bit and pulses `done` at frame end. It sits directly upstream of the serial consumer stage and builds its per-bit load/shift selection from the team's AND-OR cell function (load & parallel | ~load & shifted), here realised as registered logic with a frame controller.

## Interface
- `WIDTH`, default 8: word length in bits; legal range is WIDTH >= 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 out first; 0 shifts bit 0 out first.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load_valid`  in  1: the value on `pdata` is offered for loading.
- `load_ready`  out  1: the serializer can accept a word this cycle.
- `pdata`  in  WIDTH: parallel word; sampled only on an accepted load.
- `shift_en`  in  1: the consumer takes the current bit this cycle; 0 stalls the serializer.
- `sout`  out  1: current serial bit.
- `sout_valid`  out  1: `sout` carries a frame bit.
- `sout_last`  out  1: the current bit is the final bit of the frame.
- `busy`  out  1: a frame is in progress; equal to `sout_valid`.
- `done`  out  1: one-cycle pulse after the final bit is consumed.

## Operation
- State register: IDLE or SHIFT. A WIDTH-bit shift register `shreg` holds the word. A down-counter `cnt` of width clog2(WIDTH) tracks remaining bits. A registered flag drives `done`.
- A load is accepted when `load_valid` and `load_ready` are both 1 at a clock edge.
- `load_ready` is 1 in IDLE. In SHIFT it is 1 only when `cnt == 0` and `shift_en == 1`, which is the last-bit-consumed cycle.
- On an accepted load: `shreg <= pdata`, `cnt <= WIDTH-1`, state becomes SHIFT.
- `sout` is `shreg[WIDTH-1]` when MSB_FIRST=1, otherwise `shreg[0]`. It is combinational from `shreg` only.
- `sout_valid` and `busy` are 1 exactly when the state is SHIFT.
- `sout_last` is 1 when the state is SHIFT and `cnt == 0`.
- SHIFT with `shift_en == 1` and `cnt != 0`:
  - `shreg` shifts toward the output end, filling with 0.
  - `cnt` decrements by 1.
- SHIFT with `shift_en == 1` and `cnt == 0`:
  - `done <= 1`.
  - If a load is accepted in the same cycle, reload and stay in SHIFT with no gap.
  - Otherwise shift in a zero and go to IDLE. `shreg` is then all zeros, so `sout` reads 0 in IDLE.
- SHIFT with `shift_en == 0`: everything holds. `done <= 0`.
- `done` is 0 in every cycle not described above.
- `load_valid` during a frame, other than at the last-bit cycle, is ignored. `pdata` is not sampled and the frame is unaffected.
- `shift_en` in IDLE is ignored.
- `rst` asserted at any time, including mid-frame, aborts the frame immediately. The aborted frame produces no `done`.
- Reset values: state IDLE, `shreg` = 0, `cnt` = 0, `done` = 0. Resulting outputs: `sout` = 0, `sout_valid` = 0, `sout_last` = 0, `busy` = 0, `load_ready` = 1. Loads are not accepted while `rst` is high.

## Timing
- Load accepted at edge k: the first bit is valid from cycle k+1, with no combinational path from `pdata` to `sout`.
- With `shift_en` held at 1, a frame occupies exactly WIDTH cycles (k+1 to k+WIDTH). `sout_last` is high in cycle k+WIDTH. `done` is high in cycle k+WIDTH+1.
- Each cycle with `shift_en = 0` in SHIFT extends the frame by one cycle. The bit is held stable.
- Back-to-back: a load accepted at the last-bit edge makes the next frame's first bit valid the following cycle. `sout_valid` stays continuously 1, and `done` pulses once per completed frame.
- After a frame ends without a reload, the block is in IDLE with `load_ready` = 1 one cycle after the last bit is consumed.

## Test plan
- Reset check: assert `rst` mid-cycle with random inputs. Required: `sout`, `sout_valid`, `sout_last`, `busy` and `done` all 0, `load_ready` = 1, no acceptance until `rst` deasserts.
- MSB_FIRST=1, WIDTH=8, load 8'hC1, `shift_en` = 1. Required:
  - `sout` = 1,1,0,0,0,0,0,1 over cycles k+1 to k+8.
  - `sout_last` only in cycle k+8.
  - `done` only in cycle k+9; IDLE afterwards with `sout` = 0.
- MSB_FIRST=0, load 8'hC1. Required: `sout` = 1,0,0,0,0,0,1,1; same `sout_last` and `done` timing as above.
- Stall: load 8'hA5 with MSB_FIRST=1 and `shift_en` pattern 1,0,0,1,1,1,1,1,0,1,1. Required:
  - Bits 1,0,1,0,0,1,0,1 each held across their stall cycles.
  - Frame length 11 cycles; `done` 1 cycle after the last accepted bit.
- Back-to-back: hold `load_valid` = 1 with 8'hC1 then 8'h5A, and present 8'hFF mid-frame. Required:
  - 16 contiguous valid bits 1,1,0,0,0,0,0,1,0,1,0,1,1,0,1,0.
  - `load_ready` is 1 only at the last-bit cycles.
  - 8'hFF is never loaded; `done` pulses exactly twice.
- Reset mid-frame after 3 bits of 8'hC1. Required: outputs return to reset values immediately, and no `done` is produced. A following load of 8'h81 then serializes correctly as 1,0,0,0,0,0,0,1.
